mux_nx1_rr_seq: RTL and testbench
=================================

# mux_nx1_rr_seq

Parametrised N-to-1 registered data multiplexer for the NoC reduction/distribution tree. It extends the 2-to-1 one-hot-valid sequential mux in three ways: N inputs, a selectable round-robin arbitration mode, and a valid/ready backpressure handshake on both sides. Each beat is registered once, so the block drops into any tree level as a pipeline stage.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one data channel
- NUM_INPUT, 4, number of input channels (≥2)
- ARB_MODE, 1, 0 = strict one-hot (accept only if exactly one valid), 1 = round-robin
- SEL_WIDTH, $clog2(NUM_INPUT), derived localparam; not overridden

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_en  input  1  mux enable; 0 blocks new accepts
- i_valid  input  NUM_INPUT  per-channel valid
- i_data_bus  input  NUM_INPUT*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- o_ready  output  NUM_INPUT  per-channel accept (grant), combinational
- o_valid  output  1  output beat valid
- o_data_bus  output  DATA_WIDTH  output beat
- o_sel  output  SEL_WIDTH  source channel index of current beat
- i_ready  input  1  downstream ready
- o_conflict  output  1  one-cycle pulse: ARB_MODE=0 and more than one valid was present while slot free and i_en=1

## Operation
- The slot is free when `!o_valid || i_ready`, which gives full throughput with pass-through.
- Accept condition for channel k: `o_ready[k] & i_valid[k]`. At most one o_ready bit is high per cycle.
- o_ready is all-zero when `i_en=0` or the slot is not free.
- ARB_MODE=0:
  - o_ready[k]=1 only when i_valid is one-hot with bit k set.
  - 0 valid: nothing happens.
  - ≥2 valid: no accept, o_conflict pulses next cycle, and the inputs are not dropped (sources keep valid).
- ARB_MODE=1:
  - Round-robin priority starts at pointer `ptr`.
  - The first valid channel at index ≥ptr wins; the search wraps modulo NUM_INPUT.
  - On accept of channel g, `ptr <= (g+1) mod NUM_INPUT`. ptr does not change without an accept.
  - o_conflict is tied 0.
- On accept, the output register loads the channel data and o_sel=g, and o_valid=1.
- If the slot is free and nothing is accepted, the register clears: o_valid=0 and o_data_bus=0 (dummy data is all zeros).
- If o_valid=1 and i_ready=0, o_valid, o_data_bus and o_sel hold stable regardless of i_en, i_valid or i_data.
- i_en falling with a beat held: that beat still completes when i_ready rises. After that the output clears.

## Timing
- Reset (rst=0, async assert, sync-deasserted externally): o_valid=0, o_data_bus=0, o_sel=0, o_conflict=0, ptr=0. o_ready=0 while in reset.
- Latency: accept at edge T → o_valid/o_data_bus visible after edge T, i.e. 1 cycle.
- Throughput: 1 beat/cycle while i_ready=1.
- o_ready depends combinationally on i_valid, i_en, i_ready, o_valid and ptr. There is no combinational path from i_data_bus to any output.
- Reset mid-beat: the held beat is discarded immediately and ptr returns to 0.
- Simultaneous i_ready=1 with new accept: the old beat leaves and the new beat loads at the same edge.
- Wrap-around: ptr=NUM_INPUT-1 with an accept on NUM_INPUT-1 → ptr=0.

## Structure
- Package `mux_pkg`:
  - ARB_ONEHOT=0 and ARB_RR=1 constants
  - a `clog2`-safe SEL_WIDTH helper for NUM_INPUT=2 (SEL_WIDTH=1)
- Sub-module `rr_arbiter`:
  - parameter NUM_INPUT
  - inputs: req, ptr, en
  - outputs: one-hot grant and encoded grant index
  - combinational only
- The top owns ptr, the output register, the one-hot check and o_conflict.

## Test plan
- Reset then ARB_MODE=1, NUM_INPUT=4, i_valid=4'b1111, i_ready=1, data k=0xA0+k, for 6 cycles → o_sel sequence 0,1,2,3,0,1; o_data_bus 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1; o_valid=1 continuously.
- Backpressure: accept channel 2 (0xA2), i_ready=0 for 3 cycles → o_data_bus=0xA2 and o_sel=2 held; o_ready=0000; ptr stays 3. Then i_ready=1 → next grant is channel 3.
- ARB_MODE=0:
  - i_valid=4'b0100 → o_ready=0100 and output 0xA2 one cycle later.
  - i_valid=4'b0110 → o_ready=0000, o_conflict=1 for exactly one cycle, o_valid=0.
- i_en=0 with i_valid=4'b1111 → o_ready=0000 and o_valid=0, o_data_bus=0. i_en toggled low while a beat is held with i_ready=0 → the beat completes when i_ready=1.
- Async reset asserted mid-clock while o_valid=1, ptr=2 → o_valid=0 and o_data_bus=0 without waiting for an edge. After release, the first grant goes to channel 0.
- NUM_INPUT=2, DATA_WIDTH=8 build, ARB_MODE=1, alternate single valids 01/10 → outputs follow with 1-cycle latency and no drops.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 registered round-robin mux.
package mux_pkg;
   localparam int ARB_ONEHOT = 0;
   localparam int ARB_RR     = 1;

   // Keeps the select field at least one bit wide, even for a 2-input mux.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins.
module rr_arbiter import mux_pkg::*; #(
   parameter int NUM_INPUT = 4,
   parameter int SEL_WIDTH = sel_width(NUM_INPUT)
) (
   input  logic [NUM_INPUT-1:0] req,
   input  logic [SEL_WIDTH-1:0] ptr,
   input  logic                 en,
   output logic [NUM_INPUT-1:0] grant,
   output logic [SEL_WIDTH-1:0] grant_idx
);

   always_comb begin
      logic found;
      int   idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_INPUT) idx = idx - NUM_INPUT;
         if (en && !found && req[idx[SEL_WIDTH-1:0]]) begin
            grant[idx[SEL_WIDTH-1:0]] = 1'b1;
            grant_idx                 = idx[SEL_WIDTH-1:0];
            found                     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr_seq.sv
// N-to-1 registered mux with one-hot or round-robin selection and valid/ready on both sides.
module mux_nx1_rr_seq import mux_pkg::*; #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUT  = 4,
   parameter int ARB_MODE   = ARB_RR
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_en,
   input  logic [NUM_INPUT-1:0]            i_valid,
   input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus,
   output logic [NUM_INPUT-1:0]            o_ready,
   output logic                            o_valid,
   output logic [DATA_WIDTH-1:0]           o_data_bus,
   output logic [sel_width(NUM_INPUT)-1:0] o_sel,
   input  logic                            i_ready,
   output logic                            o_conflict
);

   localparam int SEL_WIDTH = sel_width(NUM_INPUT);
   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUT - 1);

   logic [SEL_WIDTH-1:0]  ptr;
   logic [SEL_WIDTH-1:0]  arb_ptr;
   logic [SEL_WIDTH-1:0]  grant_idx;
   logic [NUM_INPUT-1:0]  grant;
   logic [DATA_WIDTH-1:0] channel [NUM_INPUT];
   logic                  slot_free;
   logic                  multi_valid;
   logic                  single_valid;
   logic                  arb_en;
   logic                  accept;
   logic                  conflict_next;

   for (genvar k = 0; k < NUM_INPUT; k++) begin : g_channel
      assign channel[k] = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // In one-hot mode the arbiter is pinned to ptr=0 and only enabled for a single
   // requester, so its grant is exactly that requester; reset also blanks o_ready.
   always_comb begin
      slot_free     = !o_valid || i_ready;
      multi_valid   = (i_valid & (i_valid - NUM_INPUT'(1))) != '0;
      single_valid  = (i_valid != '0) && !multi_valid;
      arb_ptr       = '0;
      arb_en        = rst && i_en && slot_free;
      if (ARB_MODE == ARB_RR) begin
         arb_ptr = ptr;
      end else begin
         arb_en = arb_en && single_valid;
      end
      accept        = |grant;
      conflict_next = (ARB_MODE == ARB_ONEHOT) && i_en && slot_free && multi_valid;
   end

   rr_arbiter #(
      .NUM_INPUT (NUM_INPUT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .req       (i_valid),
      .ptr       (arb_ptr),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign o_ready = grant;

   // A free slot always reloads: either with the granted beat or with all-zero dummy data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_valid    <= 1'b0;
         o_data_bus <= '0;
         o_sel      <= '0;
         o_conflict <= 1'b0;
         ptr        <= '0;
      end else begin
         o_conflict <= conflict_next;
         if (slot_free) begin
            if (accept) begin
               o_valid    <= 1'b1;
               o_data_bus <= channel[grant_idx];
               o_sel      <= grant_idx;
            end else begin
               o_valid    <= 1'b0;
               o_data_bus <= '0;
               o_sel      <= '0;
            end
         end
         if (accept && (ARB_MODE == ARB_RR)) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_nx1_rr_seq.sv
// Self-checking bench: round-robin 4-input, one-hot 4-input and round-robin 2-input builds
// compared every cycle against a queue-free behavioural model, plus hand-computed pins.
module tb_mux_nx1_rr_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        ab_en    = 1'b0;
   logic        ab_ready = 1'b0;
   logic [3:0]  ab_valid = 4'b0;
   logic [31:0] ab_ch [4];
   logic [127:0] ab_data;
   assign ab_data = {ab_ch[3], ab_ch[2], ab_ch[1], ab_ch[0]};

   logic        c_en     = 1'b0;
   logic        c_ready  = 1'b0;
   logic [1:0]  c_valid  = 2'b0;
   logic [7:0]  c_ch [2];
   logic [15:0] c_data;
   logic [31:0] c_lane [4];
   assign c_data    = {c_ch[1], c_ch[0]};
   assign c_lane[0] = {24'b0, c_ch[0]};
   assign c_lane[1] = {24'b0, c_ch[1]};
   assign c_lane[2] = 32'b0;
   assign c_lane[3] = 32'b0;

   logic [3:0]  a_ready, b_ready;
   logic        a_valid, b_valid, a_conf, b_conf;
   logic [31:0] a_data, b_data;
   logic [1:0]  a_sel, b_sel;
   logic [1:0]  c_oready;
   logic        c_ovalid, c_conf;
   logic [7:0]  c_odata;
   logic [0:0]  c_sel;

   mux_nx1_rr_seq #(.DATA_WIDTH(32), .NUM_INPUT(4), .ARB_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .i_en(ab_en), .i_valid(ab_valid), .i_data_bus(ab_data),
      .o_ready(a_ready), .o_valid(a_valid), .o_data_bus(a_data), .o_sel(a_sel),
      .i_ready(ab_ready), .o_conflict(a_conf));

   mux_nx1_rr_seq #(.DATA_WIDTH(32), .NUM_INPUT(4), .ARB_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .i_en(ab_en), .i_valid(ab_valid), .i_data_bus(ab_data),
      .o_ready(b_ready), .o_valid(b_valid), .o_data_bus(b_data), .o_sel(b_sel),
      .i_ready(ab_ready), .o_conflict(b_conf));

   mux_nx1_rr_seq #(.DATA_WIDTH(8), .NUM_INPUT(2), .ARB_MODE(1)) dut_c (
      .clk(clk), .rst(rst), .i_en(c_en), .i_valid(c_valid), .i_data_bus(c_data),
      .o_ready(c_oready), .o_valid(c_ovalid), .o_data_bus(c_odata), .o_sel(c_sel),
      .i_ready(c_ready), .o_conflict(c_conf));

   // Model state per build: 0 = A (rr, 4), 1 = B (one-hot, 4), 2 = C (rr, 2).
   logic        m_valid [3];
   logic [31:0] m_data  [3];
   int          m_sel   [3];
   int          m_ptr   [3];
   logic        m_conf  [3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Which channel the rules grant this cycle, or -1 for none.
   function automatic int pick(input int mode, input int n, input logic [3:0] valid,
                               input logic en, input logic ready, input logic ovalid,
                               input int ptr, input logic rstn);
      int cnt;
      int last;
      cnt  = 0;
      last = -1;
      if (!rstn || !en || (ovalid && !ready)) return -1;
      for (int k = 0; k < n; k++) begin
         if (valid[k]) begin
            cnt++;
            last = k;
         end
      end
      if (mode == 0) return (cnt == 1) ? last : -1;
      for (int i = 0; i < n; i++) begin
         if (valid[(ptr + i) % n]) return (ptr + i) % n;
      end
      return -1;
   endfunction

   task automatic updateModel(input int d, input int mode, input int n, input logic [3:0] valid,
                              input logic en, input logic ready, input logic [31:0] lane [4]);
      int   g;
      logic slot;
      slot = !m_valid[d] || ready;
      g    = pick(mode, n, valid, en, ready, m_valid[d], m_ptr[d], 1'b1);
      m_conf[d] <= (mode == 0) && en && slot && ($countones(valid) >= 2);
      if (slot) begin
         if (g >= 0) begin
            m_valid[d] <= 1'b1;
            m_data[d]  <= lane[g];
            m_sel[d]   <= g;
            if (mode == 1) m_ptr[d] <= (g + 1) % n;
         end else begin
            m_valid[d] <= 1'b0;
            m_data[d]  <= 32'b0;
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            m_valid[d] <= 1'b0;
            m_data[d]  <= 32'b0;
            m_sel[d]   <= 0;
            m_ptr[d]   <= 0;
            m_conf[d]  <= 1'b0;
         end
      end else begin
         updateModel(0, 1, 4, ab_valid, ab_en, ab_ready, ab_ch);
         updateModel(1, 0, 4, ab_valid, ab_en, ab_ready, ab_ch);
         updateModel(2, 1, 2, {2'b00, c_valid}, c_en, c_ready, c_lane);
      end
   end

   task automatic checkOutput(input string tag, input int d, input int mode, input int n,
                              input logic [3:0] valid, input logic en, input logic ready,
                              input logic [3:0] act_rdy, input logic act_v,
                              input logic [31:0] act_d, input int act_sel, input logic act_c);
      int         g;
      logic [3:0] exp_rdy;
      g       = pick(mode, n, valid, en, ready, m_valid[d], m_ptr[d], rst);
      exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
      check({tag, ".o_ready"}, 64'(act_rdy), 64'(exp_rdy));
      check({tag, ".o_valid"}, 64'(act_v), 64'(m_valid[d]));
      check({tag, ".o_data_bus"}, 64'(act_d), 64'(m_data[d]));
      check({tag, ".o_conflict"}, 64'(act_c), 64'(m_conf[d]));
      if (m_valid[d]) check({tag, ".o_sel"}, 64'(act_sel), 64'(m_sel[d]));
   endtask

   always @(negedge clk) begin
      checkOutput("A", 0, 1, 4, ab_valid, ab_en, ab_ready, a_ready, a_valid, a_data, int'(a_sel), a_conf);
      checkOutput("B", 1, 0, 4, ab_valid, ab_en, ab_ready, b_ready, b_valid, b_data, int'(b_sel), b_conf);
      checkOutput("C", 2, 1, 2, {2'b00, c_valid}, c_en, c_ready, {2'b00, c_oready}, c_ovalid,
                  {24'b0, c_odata}, int'(c_sel), c_conf);
   end

   task automatic applyStimulus(input logic [3:0] v, input logic en, input logic rdy);
      ab_valid = v;
      ab_en    = en;
      ab_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      for (int k = 0; k < 4; k++) ab_ch[k] = 32'hA0 + 32'(k);
      c_ch[0] = 8'h11;
      c_ch[1] = 8'h22;
      #1 rst = 1'b0;
      #1 check("reset.o_ready", 64'(a_ready), 64'h0);
      check("reset.o_valid", 64'(a_valid), 64'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // Round-robin sweep with every channel requesting.
      applyStimulus(4'b1111, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_seq.o_sel", 64'(a_sel), 64'(exp_seq[i]));
         check("rr_seq.o_data_bus", 64'(a_data), 64'hA0 + 64'(exp_seq[i]));
         check("rr_seq.o_valid", 64'(a_valid), 64'h1);
         if (i == 0) check("onehot_all.o_conflict", 64'(b_conf), 64'h1);
      end

      // Backpressure holds channel 2, then the next grant is channel 3.
      tick();
      check("bp_accept.o_data_bus", 64'(a_data), 64'hA2);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      #1 check("bp.o_ready", 64'(a_ready), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold.o_data_bus", 64'(a_data), 64'hA2);
         check("bp_hold.o_sel", 64'(a_sel), 64'h2);
      end
      applyStimulus(4'b1111, 1'b1, 1'b1);
      #1 check("bp_release.o_ready", 64'(a_ready), 64'h8);
      tick();
      check("bp_release.o_sel", 64'(a_sel), 64'h3);

      // One-hot mode: single requester accepted, two requesters flag a conflict.
      applyStimulus(4'b0100, 1'b1, 1'b1);
      #1 check("onehot.o_ready", 64'(b_ready), 64'h4);
      tick();
      check("onehot.o_data_bus", 64'(b_data), 64'hA2);
      applyStimulus(4'b0110, 1'b1, 1'b1);
      #1 check("conflict.o_ready", 64'(b_ready), 64'h0);
      tick();
      check("conflict.o_conflict", 64'(b_conf), 64'h1);
      check("conflict.o_valid", 64'(b_valid), 64'h0);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      tick();
      check("conflict_end.o_conflict", 64'(b_conf), 64'h0);

      // Enable low blocks accepts; a held beat still drains when ready returns.
      applyStimulus(4'b1111, 1'b0, 1'b1);
      #1 check("en_low.o_ready", 64'(a_ready), 64'h0);
      tick();
      check("en_low.o_valid", 64'(a_valid), 64'h0);
      check("en_low.o_data_bus", 64'(a_data), 64'h0);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      tick();
      check("en_hold_load.o_data_bus", 64'(a_data), 64'hA2);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      repeat (2) tick();
      check("en_hold.o_valid", 64'(a_valid), 64'h1);
      applyStimulus(4'b1111, 1'b0, 1'b1);
      #1 check("en_drain.o_valid", 64'(a_valid), 64'h1);
      tick();
      check("en_drained.o_valid", 64'(a_valid), 64'h0);

      // Async reset mid-cycle while a beat is held and ptr=2.
      applyStimulus(4'b0010, 1'b1, 1'b1);
      tick();
      check("pre_reset.o_sel", 64'(a_sel), 64'h1);
      #1 rst = 1'b0;
      #1 check("async_reset.o_valid", 64'(a_valid), 64'h0);
      check("async_reset.o_data_bus", 64'(a_data), 64'h0);
      @(posedge clk);
      #2 rst = 1'b1;
      applyStimulus(4'b1111, 1'b1, 1'b1);
      #1 check("post_reset.o_ready", 64'(a_ready), 64'h1);
      tick();
      check("post_reset.o_sel", 64'(a_sel), 64'h0);

      // Two-input build alternating single requesters.
      applyStimulus(4'b0000, 1'b1, 1'b1);
      c_en    = 1'b1;
      c_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         c_valid = (i % 2 == 1) ? 2'b10 : 2'b01;
         tick();
         check("n2.o_data_bus", 64'(c_odata), (i % 2 == 1) ? 64'h22 : 64'h11);
         check("n2.o_sel", 64'(c_sel), 64'(i % 2));
      end

      // Randomised traffic, checked every cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < 4; k++) ab_ch[k] = $urandom;
         c_ch[0] = 8'($urandom);
         c_ch[1] = 8'($urandom);
         applyStimulus(4'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
         c_valid = 2'($urandom);
         c_en    = ($urandom_range(0, 9) != 0);
         c_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
